// File: rtl/xreg_field_pkg.sv
// xreg_field_pkg: access-type enums and sizing helper shared by the register field slice
package xreg_field_pkg;
  typedef enum logic [2:0] {SW_RO, SW_RW, SW_RW1C, SW_RW1S, SW_ROC, SW_ConC, SW_WonC} sw_type_e;
  typedef enum logic [1:0] {HW_NONE, HW_WR, HW_STICKY, HW_CNT} hw_type_e;
  function automatic int be_w(input int w);
    return (w + 7) / 8;
  endfunction
endpackage

// File: rtl/xreg_field_sw_next.sv
// xreg_field_sw_next: picks the winning SW port, merges byte lanes and applies the SW access type
module xreg_field_sw_next
  import xreg_field_pkg::*;
#(
  parameter int F_WIDTH = 8,
  parameter int SW_CNT = 1,
  parameter sw_type_e SW_TYPE = SW_RW
) (
  input  logic [F_WIDTH-1:0]               val,
  input  logic [SW_CNT-1:0]                sw_wr,
  input  logic [SW_CNT-1:0]                sw_rd,
  input  logic [F_WIDTH*SW_CNT-1:0]        sw_wr_data,
  input  logic [be_w(F_WIDTH)*SW_CNT-1:0]  sw_be,
  input  logic                             alter,
  output logic [F_WIDTH-1:0]               sw_nxt,
  output logic                             sw_hit
);
  localparam int BE_W = be_w(F_WIDTH);
  logic rd_clr;
  logic [SW_CNT-1:0] req;
  logic [F_WIDTH-1:0] d, m, dm;
  logic [BE_W-1:0] be;
  assign rd_clr = SW_TYPE == SW_ROC || (SW_TYPE == SW_ConC && !alter);
  assign req = rd_clr ? sw_rd : sw_wr;
  // walk from the highest port down so the lowest requesting index wins
  always_comb begin
    d = '0;
    be = '0;
    for (int p = SW_CNT - 1; p >= 0; p--)
      if (req[p]) begin
        d = sw_wr_data[p*F_WIDTH +: F_WIDTH];
        be = sw_be[p*BE_W +: BE_W];
      end
  end
  always_comb begin
    m = '0;
    for (int i = 0; i < F_WIDTH; i++) m[i] = be[i/8];
  end
  assign dm = d & m;
  assign sw_hit = |req && SW_TYPE != SW_RO && (SW_TYPE != SW_WonC || alter);
  assign sw_nxt = !sw_hit ? val :
                  rd_clr ? '0 :
                  (SW_TYPE == SW_RW1C || SW_TYPE == SW_ConC) ? val & ~dm :
                  SW_TYPE == SW_RW1S ? val | dm :
                  (val & ~m) | dm;
endmodule

// File: rtl/xreg_field.sv
// xreg_field: one register field flop merging SW access, HW load/set/clear and HW event counting
module xreg_field
  import xreg_field_pkg::*;
#(
  parameter int F_WIDTH = 8,
  parameter int SW_CNT = 1,
  parameter sw_type_e SW_TYPE = SW_RW,
  parameter hw_type_e HW_TYPE = HW_NONE,
  parameter bit HW_PRIO = 1'b0,
  parameter bit CNT_SAT = 1'b1,
  parameter logic [F_WIDTH-1:0] RST_VAL = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [SW_CNT-1:0]                sw_wr,
  input  logic [SW_CNT-1:0]                sw_rd,
  input  logic [F_WIDTH*SW_CNT-1:0]        sw_wr_data,
  input  logic [be_w(F_WIDTH)*SW_CNT-1:0]  sw_be,
  input  logic                             sw_type_alter_signal,
  input  logic                             hw_we,
  input  logic [F_WIDTH-1:0]               hw_wr_data,
  input  logic [F_WIDTH-1:0]               hw_set,
  input  logic [F_WIDTH-1:0]               hw_clr,
  input  logic                             hw_inc,
  output logic [F_WIDTH-1:0]               field_value,
  output logic                             sw_modified,
  output logic                             hw_conflict,
  output logic                             cnt_ovf
);
  if (int'(SW_TYPE) > int'(SW_WonC) || (HW_TYPE != HW_NONE && SW_TYPE == SW_RO && !HW_PRIO)) begin : g_illegal
    $fatal(1, "xreg_field: illegal SW_TYPE/HW_TYPE/HW_PRIO combination");
  end
  logic [F_WIDTH-1:0] sw_nxt, inc, base, nxt;
  logic sw_hit, hw_hit, sw_eff, hw_eff, ovf;
  xreg_field_sw_next #(.F_WIDTH(F_WIDTH), .SW_CNT(SW_CNT), .SW_TYPE(SW_TYPE)) u_sw (
    .val(field_value),
    .sw_wr(sw_wr),
    .sw_rd(sw_rd),
    .sw_wr_data(sw_wr_data),
    .sw_be(sw_be),
    .alter(sw_type_alter_signal),
    .sw_nxt(sw_nxt),
    .sw_hit(sw_hit)
  );
  assign inc = field_value + F_WIDTH'(1);
  // sticky HW never competes: SW result first, then clr, then set so set wins per bit
  always_comb begin
    hw_hit = HW_TYPE == HW_WR ? hw_we :
             HW_TYPE == HW_STICKY ? |(hw_set | hw_clr) :
             HW_TYPE == HW_CNT ? hw_inc : 1'b0;
    sw_eff = sw_hit && !(hw_hit && HW_PRIO && HW_TYPE != HW_STICKY);
    hw_eff = hw_hit && (!sw_hit || HW_PRIO || HW_TYPE == HW_STICKY);
    base = sw_eff ? sw_nxt : field_value;
    nxt = HW_TYPE == HW_STICKY ? (base & ~hw_clr) | hw_set :
          HW_TYPE == HW_WR && hw_eff ? hw_wr_data :
          HW_TYPE == HW_CNT && hw_eff ? (CNT_SAT && &field_value ? field_value : inc) :
          base;
    ovf = HW_TYPE == HW_CNT && hw_eff && (CNT_SAT ? (&field_value || &inc) : &field_value);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      field_value <= RST_VAL;
      sw_modified <= 1'b0;
      hw_conflict <= 1'b0;
      cnt_ovf <= 1'b0;
    end else begin
      field_value <= nxt;
      sw_modified <= sw_eff;
      hw_conflict <= sw_hit && hw_hit;
      cnt_ovf <= ovf;
    end
endmodule

// File: tb/tb_xreg_field.sv
// tb_xreg_field: several xreg_field configurations driven by shared stimulus and checked against a bench model
module tb_xreg_field;
  import xreg_field_pkg::*;
  logic clk, rst_n, alter, hw_we, hw_inc;
  logic [1:0] sw_wr, sw_rd;
  logic [31:0] wd;
  logic [3:0] be;
  logic [15:0] hwd;
  logic [7:0] hset, hclr;
  logic [7:0] a_val, c_val, cc_val, wc_val;
  logic [15:0] b_val;
  logic [3:0] s_val, w_val;
  logic a_mod, a_conf, a_ovf, b_mod, b_conf, b_ovf, c_mod, c_conf, c_ovf;
  logic s_mod, s_conf, s_ovf, w_mod, w_conf, w_ovf;
  logic cc_mod, cc_conf, cc_ovf, wc_mod, wc_conf, wc_ovf;
  int nvec, nmis;

  xreg_field #(.F_WIDTH(8), .SW_TYPE(SW_RW1C), .HW_TYPE(HW_STICKY), .RST_VAL(8'hA5)) d_a (
    .clk(clk), .rst_n(rst_n), .sw_wr(sw_wr[0]), .sw_rd(sw_rd[0]), .sw_wr_data(wd[7:0]), .sw_be(be[0]),
    .sw_type_alter_signal(alter), .hw_we(hw_we), .hw_wr_data(hwd[7:0]), .hw_set(hset), .hw_clr(hclr),
    .hw_inc(hw_inc), .field_value(a_val), .sw_modified(a_mod), .hw_conflict(a_conf), .cnt_ovf(a_ovf));
  xreg_field #(.F_WIDTH(16), .SW_CNT(2), .SW_TYPE(SW_RW), .HW_TYPE(HW_WR), .HW_PRIO(1'b0), .RST_VAL(16'hABCD)) d_b (
    .clk(clk), .rst_n(rst_n), .sw_wr(sw_wr), .sw_rd(sw_rd), .sw_wr_data(wd), .sw_be(be),
    .sw_type_alter_signal(alter), .hw_we(hw_we), .hw_wr_data(hwd), .hw_set({8'h00, hset}), .hw_clr({8'h00, hclr}),
    .hw_inc(hw_inc), .field_value(b_val), .sw_modified(b_mod), .hw_conflict(b_conf), .cnt_ovf(b_ovf));
  xreg_field #(.F_WIDTH(8), .SW_TYPE(SW_RW), .HW_TYPE(HW_WR), .HW_PRIO(1'b1), .RST_VAL(8'h00)) d_c (
    .clk(clk), .rst_n(rst_n), .sw_wr(sw_wr[0]), .sw_rd(sw_rd[0]), .sw_wr_data(wd[7:0]), .sw_be(be[0]),
    .sw_type_alter_signal(alter), .hw_we(hw_we), .hw_wr_data(hwd[7:0]), .hw_set(hset), .hw_clr(hclr),
    .hw_inc(hw_inc), .field_value(c_val), .sw_modified(c_mod), .hw_conflict(c_conf), .cnt_ovf(c_ovf));
  xreg_field #(.F_WIDTH(4), .SW_TYPE(SW_RW), .HW_TYPE(HW_CNT), .CNT_SAT(1'b1), .RST_VAL(4'h0)) d_s (
    .clk(clk), .rst_n(rst_n), .sw_wr(sw_wr[0]), .sw_rd(sw_rd[0]), .sw_wr_data(wd[3:0]), .sw_be(be[0]),
    .sw_type_alter_signal(alter), .hw_we(hw_we), .hw_wr_data(hwd[3:0]), .hw_set(hset[3:0]), .hw_clr(hclr[3:0]),
    .hw_inc(hw_inc), .field_value(s_val), .sw_modified(s_mod), .hw_conflict(s_conf), .cnt_ovf(s_ovf));
  xreg_field #(.F_WIDTH(4), .SW_TYPE(SW_RW), .HW_TYPE(HW_CNT), .CNT_SAT(1'b0), .RST_VAL(4'h0)) d_w (
    .clk(clk), .rst_n(rst_n), .sw_wr(sw_wr[0]), .sw_rd(sw_rd[0]), .sw_wr_data(wd[3:0]), .sw_be(be[0]),
    .sw_type_alter_signal(alter), .hw_we(hw_we), .hw_wr_data(hwd[3:0]), .hw_set(hset[3:0]), .hw_clr(hclr[3:0]),
    .hw_inc(hw_inc), .field_value(w_val), .sw_modified(w_mod), .hw_conflict(w_conf), .cnt_ovf(w_ovf));
  xreg_field #(.F_WIDTH(8), .SW_TYPE(SW_ConC), .HW_TYPE(HW_NONE), .RST_VAL(8'hFF)) d_cc (
    .clk(clk), .rst_n(rst_n), .sw_wr(sw_wr[0]), .sw_rd(sw_rd[0]), .sw_wr_data(wd[7:0]), .sw_be(be[0]),
    .sw_type_alter_signal(alter), .hw_we(hw_we), .hw_wr_data(hwd[7:0]), .hw_set(hset), .hw_clr(hclr),
    .hw_inc(hw_inc), .field_value(cc_val), .sw_modified(cc_mod), .hw_conflict(cc_conf), .cnt_ovf(cc_ovf));
  xreg_field #(.F_WIDTH(8), .SW_TYPE(SW_WonC), .HW_TYPE(HW_NONE), .RST_VAL(8'h3C)) d_wc (
    .clk(clk), .rst_n(rst_n), .sw_wr(sw_wr[0]), .sw_rd(sw_rd[0]), .sw_wr_data(wd[7:0]), .sw_be(be[0]),
    .sw_type_alter_signal(alter), .hw_we(hw_we), .hw_wr_data(hwd[7:0]), .hw_set(hset), .hw_clr(hclr),
    .hw_inc(hw_inc), .field_value(wc_val), .sw_modified(wc_mod), .hw_conflict(wc_conf), .cnt_ovf(wc_ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic wr, rd, alt;
    logic [7:0] wd;
    logic hwe;
    logic [7:0] hwd, c_v;
    logic c_m, c_f;
    logic [7:0] cc_v;
    logic cc_m;
    logic [7:0] wc_v;
    logic wc_m;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    sw_wr = '0; sw_rd = '0; wd = '0; be = 4'hF; alter = 1'b0;
    hw_we = 1'b0; hwd = '0; hset = '0; hclr = '0; hw_inc = 1'b0;
  endtask

  task automatic do_reset;
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [7:0] ma, na;
  logic [15:0] mb, nb;
  logic ea_mod, ea_conf, eb_mod, eb_conf;
  int p;

  initial begin
    nvec = 0; nmis = 0;
    rst_n = 1'b1;
    idle();
    tbl[0] = '{1'b1, 1'b0, 1'b1, 8'hF0, 1'b0, 8'h00, 8'hF0, 1'b1, 1'b0, 8'h0F, 1'b1, 8'hF0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 8'h00, 8'h55, 1'b1, 1'b0, 8'h0F, 1'b0, 8'hF0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h55, 1'b0, 1'b0, 8'h00, 1'b1, 8'hF0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 8'h22, 8'h22, 1'b0, 1'b1, 8'h00, 1'b0, 8'hF0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h99, 8'h99, 1'b0, 1'b0, 8'h00, 1'b0, 8'hF0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 8'h5A, 1'b0};
    // reset values, reset during a write, first edge after release
    #2 rst_n = 1'b0;
    #1;
    chk("rst_val", a_val, 8'hA5);
    chk("rst_mod", a_mod, 0);
    chk("rst_conf", a_conf, 0);
    chk("rst_ovf", s_ovf, 0);
    tick();
    rst_n = 1'b1;
    tick();
    sw_wr = 2'b01; wd = 32'hFF;
    #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    chk("rst_mid_val", a_val, 8'hA5);
    tick();
    chk("rst_post_val", a_val, 8'hA5);
    chk("rst_post_mod", a_mod, 0);
    sw_wr = 2'b01; wd = 32'h05;
    tick();
    chk("rst_first_val", a_val, 8'hA0);
    chk("rst_first_mod", a_mod, 1);
    // two RW ports on one cycle, port0 wins with a partial byte enable
    do_reset();
    sw_wr = 2'b11; wd = {16'hFFFF, 16'h1234}; be = 4'b1101;
    tick();
    chk("rw2_val", b_val, 16'hAB34);
    chk("rw2_mod", b_mod, 1);
    chk("rw2_conf", b_conf, 0);
    // RW1C merged with sticky set
    do_reset();
    hclr = 8'hF0; hset = 8'h0F;
    tick();
    chk("stk_pre_val", a_val, 8'h0F);
    chk("stk_pre_conf", a_conf, 0);
    hclr = 8'h00; hset = 8'h01; sw_wr = 2'b01; wd = 32'h03;
    tick();
    chk("stk_val", a_val, 8'h0D);
    chk("stk_conf", a_conf, 1);
    chk("stk_mod", a_mod, 1);
    idle();
    tick();
    chk("stk_conf_clr", a_conf, 0);
    // counters: saturate vs wrap
    do_reset();
    hw_inc = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("sat_val%0d", k), s_val, k > 15 ? 15 : k);
      chk($sformatf("sat_ovf%0d", k), s_ovf, k >= 15);
      chk($sformatf("wrap_val%0d", k), w_val, k % 16);
      chk($sformatf("wrap_ovf%0d", k), w_ovf, k == 16);
    end
    sw_wr = 2'b01; wd = 32'h3;
    tick();
    chk("cnt_drop_val", s_val, 4'h3);
    chk("cnt_drop_conf", s_conf, 1);
    chk("cnt_drop_ovf", s_ovf, 0);
    chk("cnt_drop_wval", w_val, 4'h3);
    // HW_WR priority both ways
    do_reset();
    sw_wr = 2'b01; wd = 32'h0011; hw_we = 1'b1; hwd = 16'h0022;
    tick();
    chk("prio0_val", b_val, 16'h0011);
    chk("prio0_conf", b_conf, 1);
    chk("prio0_mod", b_mod, 1);
    chk("prio1_val", c_val, 8'h22);
    chk("prio1_conf", c_conf, 1);
    chk("prio1_mod", c_mod, 0);
    // table: RW/HW_WR prio1, ConC, WonC
    do_reset();
    for (int i = 0; i < 7; i++) begin
      idle();
      sw_wr[0] = tbl[i].wr; sw_rd[0] = tbl[i].rd; alter = tbl[i].alt; wd[7:0] = tbl[i].wd;
      hw_we = tbl[i].hwe; hwd[7:0] = tbl[i].hwd;
      tick();
      chk($sformatf("t%0d_c_val", i), c_val, tbl[i].c_v);
      chk($sformatf("t%0d_c_mod", i), c_mod, tbl[i].c_m);
      chk($sformatf("t%0d_c_conf", i), c_conf, tbl[i].c_f);
      chk($sformatf("t%0d_cc_val", i), cc_val, tbl[i].cc_v);
      chk($sformatf("t%0d_cc_mod", i), cc_mod, tbl[i].cc_m);
      chk($sformatf("t%0d_wc_val", i), wc_val, tbl[i].wc_v);
      chk($sformatf("t%0d_wc_mod", i), wc_mod, tbl[i].wc_m);
    end
    // random against the bench model of d_a and d_b
    do_reset();
    ma = 8'hA5; mb = 16'hABCD;
    for (int n = 0; n < 400; n++) begin
      sw_wr = 2'($urandom); sw_rd = 2'($urandom); wd = $urandom; be = 4'($urandom);
      alter = 1'($urandom); hw_we = 1'($urandom); hwd = 16'($urandom); hw_inc = 1'($urandom);
      hset = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'h00;
      hclr = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'h00;
      na = (sw_wr[0] && be[0]) ? ma & ~wd[7:0] : ma;
      for (int i = 0; i < 8; i++)
        if (hset[i]) na[i] = 1'b1;
        else if (hclr[i]) na[i] = 1'b0;
      ea_mod = sw_wr[0];
      ea_conf = sw_wr[0] && (hset != 0 || hclr != 0);
      p = sw_wr[0] ? 0 : sw_wr[1] ? 1 : -1;
      nb = mb;
      if (p >= 0) begin
        for (int l = 0; l < 2; l++)
          if (be[p*2+l]) nb[l*8 +: 8] = wd[p*16+l*8 +: 8];
      end else if (hw_we) nb = hwd;
      eb_mod = p >= 0;
      eb_conf = p >= 0 && hw_we;
      tick();
      chk("rnd_a_val", a_val, na);
      chk("rnd_a_mod", a_mod, ea_mod);
      chk("rnd_a_conf", a_conf, ea_conf);
      chk("rnd_b_val", b_val, nb);
      chk("rnd_b_mod", b_mod, eb_mod);
      chk("rnd_b_conf", b_conf, eb_conf);
      ma = na; mb = nb;
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
